mem_merge: RTL and testbench



---
 rtl/mem_merge_pkg.sv | 29 ++
 rtl/mem_merge_stream.sv | 111 +++++++++++
 rtl/mem_merge.sv | 100 ++++++++++
 tb/tb_mem_merge.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_merge_pkg.sv
// Shared types for the request merger: stream pipeline/select modes, clock
// descriptor, and id-width helpers used by both the wrapper and the stream core.
package mem_merge_pkg;

  typedef enum logic [0:0] {
    STREAM_PIPELINE_MODE_REGISTERED  = 1'b0,
    STREAM_PIPELINE_MODE_TRANSPARENT = 1'b1
  } stream_pipeline_mode_t;

  typedef enum logic [0:0] {
    STREAM_SELECT_MODE_ROUND_ROBIN = 1'b0,
    STREAM_SELECT_MODE_PRIORITY    = 1'b1
  } stream_select_mode_t;

  typedef struct packed {
    logic [31:0] freq_khz;
    logic [7:0]  domain;
  } std_clock_info_t;

  // A single port still carries a 1-bit grant index so vectors never go zero-width.
  function automatic int sub_id_width(input int ports);
    return (ports > 1) ? $clog2(ports) : 1;
  endfunction

  function automatic int out_id_width(input int ports, input int pre_id_width);
    return (ports > 1) ? pre_id_width + $clog2(ports) : pre_id_width;
  endfunction

endpackage

// File: rtl/mem_merge_stream.sv
// Generic N:1 stream merge: arbiter (round-robin or fixed priority), rr pointer,
// optional output register, and the grant index presented alongside the payload.
module mem_merge_stream
  import mem_merge_pkg::*;
#(
  parameter std_clock_info_t       CLOCK_INFO    = '0,
  parameter stream_pipeline_mode_t PIPELINE_MODE = STREAM_PIPELINE_MODE_REGISTERED,
  parameter stream_select_mode_t   SELECT_MODE   = STREAM_SELECT_MODE_ROUND_ROBIN,
  parameter int                    PORTS         = 2,
  parameter type                   T             = logic,
  parameter int                    ID_WIDTH      = sub_id_width(PORTS)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [PORTS-1:0]    in_valid_i,
  output logic [PORTS-1:0]    in_ready_o,
  input  T     [PORTS-1:0]    in_data_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output T                    out_data_o,
  output logic [ID_WIDTH-1:0] out_id_o,
  output logic [ID_WIDTH-1:0] rr_o
);

  if (PORTS < 1) begin : g_bad_ports
    $error("mem_merge_stream: PORTS must be at least 1");
  end
  if ($bits(CLOCK_INFO) == 0) begin : g_bad_clock
    $error("mem_merge_stream: empty clock descriptor");
  end

  logic [ID_WIDTH-1:0] rr_q, rr_d, grant;
  logic                grant_valid, open, fire;
  int                  idx;

  // Scan order starts at rr in round-robin mode, at port 0 in priority mode.
  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    idx         = 0;
    for (int i = 0; i < PORTS; i++) begin
      idx = (SELECT_MODE == STREAM_SELECT_MODE_ROUND_ROBIN) ? (int'(rr_q) + i) % PORTS : i;
      if (!grant_valid && in_valid_i[ID_WIDTH'(idx)]) begin
        grant_valid = 1'b1;
        grant       = ID_WIDTH'(idx);
      end
    end
  end

  assign fire = rst_ni && open && grant_valid;

  always_comb begin
    in_ready_o = '0;
    if (fire) in_ready_o[grant] = 1'b1;
  end

  always_comb begin
    rr_d = rr_q;
    if (fire) rr_d = (int'(grant) == PORTS - 1) ? '0 : grant + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rr_q <= '0;
    else         rr_q <= rr_d;
  end

  assign rr_o = rr_q;

  if (PIPELINE_MODE == STREAM_PIPELINE_MODE_REGISTERED) begin : g_reg
    T                    data_q, data_d;
    logic [ID_WIDTH-1:0] id_q, id_d;
    logic                valid_q, valid_d;

    assign open = !valid_q || out_ready_i;

    // A drain and a load in the same cycle replace the register without a bubble.
    always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      id_d    = id_q;
      if (out_ready_i) valid_d = 1'b0;
      if (fire) begin
        valid_d = 1'b1;
        data_d  = in_data_i[grant];
        id_d    = grant;
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        valid_q <= 1'b0;
        data_q  <= '0;
        id_q    <= '0;
      end else begin
        valid_q <= valid_d;
        data_q  <= data_d;
        id_q    <= id_d;
      end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
    assign out_id_o    = id_q;
  end else begin : g_thru
    assign open        = out_ready_i;
    assign out_valid_o = rst_ni && grant_valid;
    assign out_data_o  = in_data_i[grant];
    assign out_id_o    = grant;
  end

endmodule

// File: rtl/mem_merge.sv
// Merges PORTS memory request streams onto one; the winning port index is
// prepended to the request id so the response splitter can route it back.
module mem_merge
  import mem_merge_pkg::*;
#(
  parameter std_clock_info_t       CLOCK_INFO         = '0,
  parameter stream_pipeline_mode_t PIPELINE_MODE      = STREAM_PIPELINE_MODE_REGISTERED,
  parameter stream_select_mode_t   STREAM_SELECT_MODE = STREAM_SELECT_MODE_ROUND_ROBIN,
  parameter int                    PORTS              = 2,
  parameter int                    ADDR_WIDTH         = 32,
  parameter int                    DATA_WIDTH         = 32,
  parameter int                    WE_WIDTH           = 4,
  parameter int                    PRE_ID_WIDTH       = 4,
  parameter int                    META_WIDTH         = 1
) (
  input  logic                                         clk_i,
  input  logic                                         rst_ni,
  input  logic [PORTS-1:0]                             mem_in_valid_i,
  output logic [PORTS-1:0]                             mem_in_ready_o,
  input  logic [PORTS-1:0]                             mem_in_read_enable_i,
  input  logic [PORTS-1:0][WE_WIDTH-1:0]               mem_in_write_enable_i,
  input  logic [PORTS-1:0][ADDR_WIDTH-1:0]             mem_in_addr_i,
  input  logic [PORTS-1:0][DATA_WIDTH-1:0]             mem_in_data_i,
  input  logic [PORTS-1:0][PRE_ID_WIDTH-1:0]           mem_in_id_i,
  input  logic [PORTS-1:0][META_WIDTH-1:0]             mem_in_meta_i,
  output logic                                         mem_out_valid_o,
  input  logic                                         mem_out_ready_i,
  output logic                                         mem_out_read_enable_o,
  output logic [WE_WIDTH-1:0]                          mem_out_write_enable_o,
  output logic [ADDR_WIDTH-1:0]                        mem_out_addr_o,
  output logic [DATA_WIDTH-1:0]                        mem_out_data_o,
  output logic [out_id_width(PORTS, PRE_ID_WIDTH)-1:0] mem_out_id_o,
  output logic [META_WIDTH-1:0]                        mem_out_meta_o,
  output logic [sub_id_width(PORTS)-1:0]               dbg_rr_o
);

  localparam int SUB_ID_WIDTH = sub_id_width(PORTS);

  if ($bits(mem_out_id_o) != ((PORTS > 1) ? PRE_ID_WIDTH + SUB_ID_WIDTH : PRE_ID_WIDTH))
  begin : g_bad_id_width
    $error("mem_merge: output id width does not match PRE_ID_WIDTH plus grant bits");
  end

  typedef struct packed {
    logic                    read_enable;
    logic [WE_WIDTH-1:0]     write_enable;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   data;
    logic [PRE_ID_WIDTH-1:0] id;
    logic [META_WIDTH-1:0]   meta;
  } mem_t;

  mem_t [PORTS-1:0]        in_req;
  mem_t                    out_req;
  logic [SUB_ID_WIDTH-1:0] out_grant;

  always_comb begin
    for (int k = 0; k < PORTS; k++) begin
      in_req[k].read_enable  = mem_in_read_enable_i[k];
      in_req[k].write_enable = mem_in_write_enable_i[k];
      in_req[k].addr         = mem_in_addr_i[k];
      in_req[k].data         = mem_in_data_i[k];
      in_req[k].id           = mem_in_id_i[k];
      in_req[k].meta         = mem_in_meta_i[k];
    end
  end

  mem_merge_stream #(
    .CLOCK_INFO    (CLOCK_INFO),
    .PIPELINE_MODE (PIPELINE_MODE),
    .SELECT_MODE   (STREAM_SELECT_MODE),
    .PORTS         (PORTS),
    .T             (mem_t),
    .ID_WIDTH      (SUB_ID_WIDTH)
  ) u_stream (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (mem_in_valid_i),
    .in_ready_o  (mem_in_ready_o),
    .in_data_i   (in_req),
    .out_valid_o (mem_out_valid_o),
    .out_ready_i (mem_out_ready_i),
    .out_data_o  (out_req),
    .out_id_o    (out_grant),
    .rr_o        (dbg_rr_o)
  );

  assign mem_out_read_enable_o  = out_req.read_enable;
  assign mem_out_write_enable_o = out_req.write_enable;
  assign mem_out_addr_o         = out_req.addr;
  assign mem_out_data_o         = out_req.data;
  assign mem_out_meta_o         = out_req.meta;

  if (PORTS > 1) begin : g_tag
    assign mem_out_id_o = {out_grant, out_req.id};
  end else begin : g_pass
    assign mem_out_id_o = out_req.id;
  end

endmodule

// File: tb/tb_mem_merge.sv
// Randomized scoreboard bench for mem_merge across four configurations:
// 4-port round-robin, 4-port priority, 3-port round-robin, 1-port transparent.
`timescale 1ns/1ps
module tb_mem_merge;
  import mem_merge_pkg::*;

  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int WEW = 2;
  localparam int PIW = 2;
  localparam int MW  = 1;
  localparam int W   = 4 + 1 + WEW + AW + DW + MW;
  localparam int ND  = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- stimulus-side signals ----------------
  logic [3:0]          in_valid [ND];
  logic [3:0]          in_re    [ND];
  logic [3:0][WEW-1:0] in_we    [ND];
  logic [3:0][AW-1:0]  in_addr  [ND];
  logic [3:0][DW-1:0]  in_data  [ND];
  logic [3:0][PIW-1:0] in_id    [ND];
  logic [3:0][MW-1:0]  in_meta  [ND];
  logic                out_ready[ND];

  logic           o_valid[ND];
  logic           o_re   [ND];
  logic [WEW-1:0] o_we   [ND];
  logic [AW-1:0]  o_addr [ND];
  logic [DW-1:0]  o_data [ND];
  logic [MW-1:0]  o_meta [ND];
  logic [3:0]     o_id0, o_id1, o_id2;
  logic [1:0]     o_id3;
  logic [3:0]     rdy0, rdy1;
  logic [2:0]     rdy2;
  logic [0:0]     rdy3;
  logic [1:0]     rr0, rr1, rr2;
  logic [0:0]     rr3;

  mem_merge #(.PIPELINE_MODE(STREAM_PIPELINE_MODE_REGISTERED),
    .STREAM_SELECT_MODE(STREAM_SELECT_MODE_ROUND_ROBIN), .PORTS(4),
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WE_WIDTH(WEW), .PRE_ID_WIDTH(PIW), .META_WIDTH(MW)
  ) u_rr4 (
    .clk_i(clk), .rst_ni(rst_n),
    .mem_in_valid_i(in_valid[0]), .mem_in_ready_o(rdy0), .mem_in_read_enable_i(in_re[0]),
    .mem_in_write_enable_i(in_we[0]), .mem_in_addr_i(in_addr[0]), .mem_in_data_i(in_data[0]),
    .mem_in_id_i(in_id[0]), .mem_in_meta_i(in_meta[0]),
    .mem_out_valid_o(o_valid[0]), .mem_out_ready_i(out_ready[0]), .mem_out_read_enable_o(o_re[0]),
    .mem_out_write_enable_o(o_we[0]), .mem_out_addr_o(o_addr[0]), .mem_out_data_o(o_data[0]),
    .mem_out_id_o(o_id0), .mem_out_meta_o(o_meta[0]), .dbg_rr_o(rr0)
  );

  mem_merge #(.PIPELINE_MODE(STREAM_PIPELINE_MODE_REGISTERED),
    .STREAM_SELECT_MODE(STREAM_SELECT_MODE_PRIORITY), .PORTS(4),
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WE_WIDTH(WEW), .PRE_ID_WIDTH(PIW), .META_WIDTH(MW)
  ) u_pri4 (
    .clk_i(clk), .rst_ni(rst_n),
    .mem_in_valid_i(in_valid[1]), .mem_in_ready_o(rdy1), .mem_in_read_enable_i(in_re[1]),
    .mem_in_write_enable_i(in_we[1]), .mem_in_addr_i(in_addr[1]), .mem_in_data_i(in_data[1]),
    .mem_in_id_i(in_id[1]), .mem_in_meta_i(in_meta[1]),
    .mem_out_valid_o(o_valid[1]), .mem_out_ready_i(out_ready[1]), .mem_out_read_enable_o(o_re[1]),
    .mem_out_write_enable_o(o_we[1]), .mem_out_addr_o(o_addr[1]), .mem_out_data_o(o_data[1]),
    .mem_out_id_o(o_id1), .mem_out_meta_o(o_meta[1]), .dbg_rr_o(rr1)
  );

  mem_merge #(.PIPELINE_MODE(STREAM_PIPELINE_MODE_REGISTERED),
    .STREAM_SELECT_MODE(STREAM_SELECT_MODE_ROUND_ROBIN), .PORTS(3),
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WE_WIDTH(WEW), .PRE_ID_WIDTH(PIW), .META_WIDTH(MW)
  ) u_rr3 (
    .clk_i(clk), .rst_ni(rst_n),
    .mem_in_valid_i(in_valid[2][2:0]), .mem_in_ready_o(rdy2), .mem_in_read_enable_i(in_re[2][2:0]),
    .mem_in_write_enable_i(in_we[2][2:0]), .mem_in_addr_i(in_addr[2][2:0]),
    .mem_in_data_i(in_data[2][2:0]), .mem_in_id_i(in_id[2][2:0]), .mem_in_meta_i(in_meta[2][2:0]),
    .mem_out_valid_o(o_valid[2]), .mem_out_ready_i(out_ready[2]), .mem_out_read_enable_o(o_re[2]),
    .mem_out_write_enable_o(o_we[2]), .mem_out_addr_o(o_addr[2]), .mem_out_data_o(o_data[2]),
    .mem_out_id_o(o_id2), .mem_out_meta_o(o_meta[2]), .dbg_rr_o(rr2)
  );

  mem_merge #(.PIPELINE_MODE(STREAM_PIPELINE_MODE_TRANSPARENT),
    .STREAM_SELECT_MODE(STREAM_SELECT_MODE_ROUND_ROBIN), .PORTS(1),
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WE_WIDTH(WEW), .PRE_ID_WIDTH(PIW), .META_WIDTH(MW)
  ) u_p1 (
    .clk_i(clk), .rst_ni(rst_n),
    .mem_in_valid_i(in_valid[3][0:0]), .mem_in_ready_o(rdy3), .mem_in_read_enable_i(in_re[3][0:0]),
    .mem_in_write_enable_i(in_we[3][0:0]), .mem_in_addr_i(in_addr[3][0:0]),
    .mem_in_data_i(in_data[3][0:0]), .mem_in_id_i(in_id[3][0:0]), .mem_in_meta_i(in_meta[3][0:0]),
    .mem_out_valid_o(o_valid[3]), .mem_out_ready_i(out_ready[3]), .mem_out_read_enable_o(o_re[3]),
    .mem_out_write_enable_o(o_we[3]), .mem_out_addr_o(o_addr[3]), .mem_out_data_o(o_data[3]),
    .mem_out_id_o(o_id3), .mem_out_meta_o(o_meta[3]), .dbg_rr_o(rr3)
  );

  // ---------------- configuration lookup ----------------
  function automatic int nports(input int d);
    case (d)
      2:       return 3;
      3:       return 1;
      default: return 4;
    endcase
  endfunction

  function automatic bit is_pri(input int d);
    return d == 1;
  endfunction

  function automatic bit is_trans(input int d);
    return d == 3;
  endfunction

  function automatic logic [W-1:0] got_word(input int d);
    logic [3:0] id;
    case (d)
      0:       id = o_id0;
      1:       id = o_id1;
      2:       id = o_id2;
      default: id = {2'b00, o_id3};
    endcase
    return {id, o_re[d], o_we[d], o_addr[d], o_data[d], o_meta[d]};
  endfunction

  function automatic logic [3:0] got_rdy(input int d);
    case (d)
      0:       return rdy0;
      1:       return rdy1;
      2:       return {1'b0, rdy2};
      default: return {3'b000, rdy3};
    endcase
  endfunction

  function automatic int got_rr(input int d);
    case (d)
      0:       return int'(rr0);
      1:       return int'(rr1);
      2:       return int'(rr2);
      default: return int'(rr3);
    endcase
  endfunction

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q0[$], exp_q1[$], exp_q2[$], exp_q3[$];
  int n_checks, n_pass;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
  endtask

  task automatic q_push(input int d, input logic [W-1:0] w);
    case (d)
      0: exp_q0.push_back(w);
      1: exp_q1.push_back(w);
      2: exp_q2.push_back(w);
      default: exp_q3.push_back(w);
    endcase
  endtask

  task automatic q_pop(input int d, output logic [W-1:0] w);
    case (d)
      0: w = exp_q0.pop_front();
      1: w = exp_q1.pop_front();
      2: w = exp_q2.pop_front();
      default: w = exp_q3.pop_front();
    endcase
  endtask

  function automatic int q_size(input int d);
    case (d)
      0: return exp_q0.size();
      1: return exp_q1.size();
      2: return exp_q2.size();
      default: return exp_q3.size();
    endcase
  endfunction

  task automatic q_clear(input int d);
    case (d)
      0: exp_q0.delete();
      1: exp_q1.delete();
      2: exp_q2.delete();
      default: exp_q3.delete();
    endcase
  endtask

  // ---------------- reference model ----------------
  bit       m_full[ND];
  int       m_rr  [ND];
  bit [3:0] acc   [ND];

  function automatic int pick(input int d, input logic [3:0] v, input int ptr);
    int n;
    int k;
    n = nports(d);
    for (int i = 0; i < n; i++) begin
      k = is_pri(d) ? i : (ptr + i) % n;
      if (v[k]) return k;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] exp_word(input int d, input int g);
    logic [3:0] id;
    logic [1:0] gi;
    gi = 2'(g);
    id = (nports(d) > 1) ? {gi, in_id[d][g]} : {2'b00, in_id[d][g]};
    return {id, in_re[d][g], in_we[d][g], in_addr[d][g], in_data[d][g], in_meta[d][g]};
  endfunction

  // Predicts the grant for the coming edge from the inputs that are stable now.
  always @(negedge clk) begin
    for (int d = 0; d < ND; d++) begin
      int         g;
      bit         open;
      logic [3:0] exp_rdy;
      acc[d] = 4'b0;
      if (!rst_n) begin
        m_full[d] = 1'b0;
        m_rr[d]   = 0;
        q_clear(d);
        check($sformatf("ready_in_reset[%0d]", d), 64'(got_rdy(d)), 64'd0);
      end else begin
        check($sformatf("rr[%0d]", d), 64'(got_rr(d)), 64'(m_rr[d]));
        open    = is_trans(d) ? out_ready[d] : (!m_full[d] || out_ready[d]);
        g       = open ? pick(d, in_valid[d], m_rr[d]) : -1;
        exp_rdy = (g >= 0) ? (4'b0001 << g) : 4'b0000;
        check($sformatf("ready[%0d]", d), 64'(got_rdy(d)), 64'(exp_rdy));
        if (g >= 0) begin
          q_push(d, exp_word(d, g));
          acc[d][g] = 1'b1;
          m_rr[d]   = (g + 1) % nports(d);
        end
        if (!is_trans(d)) m_full[d] = (g >= 0) ? 1'b1 : (out_ready[d] ? 1'b0 : m_full[d]);
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    #1;
    for (int d = 0; d < ND; d++) begin
      logic [W-1:0] w;
      if (rst_n && o_valid[d] && out_ready[d]) begin
        if (q_size(d) == 0) begin
          n_checks++;
          $display("FAIL out_unexpected[%0d]: got 0x%0h expected no transfer at %0t",
                   d, got_word(d), $time);
        end else begin
          q_pop(d, w);
          check($sformatf("out_word[%0d]", d), 64'(got_word(d)), 64'(w));
        end
      end
    end
  end

  // ---------------- driver ----------------
  bit [3:0] en[ND];
  int       vprob, rprob;
  bit       fixed_id;

  always @(posedge clk) begin
    #1;
    for (int d = 0; d < ND; d++) begin
      for (int k = 0; k < nports(d); k++) begin
        if (acc[d][k] || !in_valid[d][k] || !rst_n) begin
          if (en[d][k] && $urandom_range(99) < vprob) begin
            in_valid[d][k] = 1'b1;
            in_re[d][k]    = 1'($urandom_range(1));
            in_we[d][k]    = WEW'($urandom);
            in_addr[d][k]  = AW'($urandom);
            in_data[d][k]  = DW'($urandom);
            in_id[d][k]    = fixed_id ? PIW'(k) : PIW'($urandom);
            in_meta[d][k]  = MW'($urandom);
          end else begin
            in_valid[d][k] = 1'b0;
          end
        end
      end
      out_ready[d] = ($urandom_range(99) < rprob);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic set_en_all(input bit [3:0] m);
    for (int d = 0; d < ND; d++) en[d] = m;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    vprob    = 0;
    rprob    = 0;
    fixed_id = 1'b0;
    for (int d = 0; d < ND; d++) begin
      en[d] = 4'b0; in_valid[d] = '0; in_re[d] = '0; in_we[d] = '0; in_addr[d] = '0;
      in_data[d] = '0; in_id[d] = '0; in_meta[d] = '0; out_ready[d] = 1'b0;
      m_full[d] = 1'b0; m_rr[d] = 0; acc[d] = '0;
    end

    cycles(3);
    for (int d = 0; d < ND; d++) begin
      check($sformatf("reset_valid[%0d]", d), 64'(o_valid[d]), 64'd0);
      check($sformatf("reset_rr[%0d]", d), 64'(got_rr(d)), 64'd0);
      if (!is_trans(d)) check($sformatf("reset_payload[%0d]", d), 64'(got_word(d)), 64'd0);
    end

    // Fixed ids with all ports busy; priority sees ports 1 and 3; 3-port walks rr to 2.
    rst_n    = 1'b1;
    en[0]    = 4'b1111;
    en[1]    = 4'b1010;
    en[2]    = 4'b0010;
    en[3]    = 4'b0001;
    vprob    = 100;
    rprob    = 100;
    fixed_id = 1'b1;
    cycles(12);
    en[1] = 4'b1000;
    en[2] = 4'b0001;
    cycles(6);
    en[2] = 4'b0110;
    cycles(6);

    // Backpressure hold, then release.
    rprob = 0;
    cycles(5);
    rprob = 100;
    cycles(4);

    fixed_id = 1'b0;
    vprob    = 60;
    rprob    = 70;
    set_en_all(4'b1111);
    cycles(300);

    // Stall outputs so registers hold a request, then reset asynchronously.
    rprob = 0;
    vprob = 100;
    cycles(3);
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < ND; d++) begin
      check($sformatf("async_reset_valid[%0d]", d), 64'(o_valid[d]), 64'd0);
      check($sformatf("async_reset_rr[%0d]", d), 64'(got_rr(d)), 64'd0);
    end
    set_en_all(4'b0000);
    en[0] = 4'b1000;
    cycles(2);
    rst_n = 1'b1;
    rprob = 100;
    cycles(10);

    set_en_all(4'b1111);
    vprob = 70;
    rprob = 60;
    cycles(300);

    set_en_all(4'b0000);
    rprob = 100;
    cycles(12);
    for (int d = 0; d < ND; d++)
      check($sformatf("drained[%0d]", d), 64'(q_size(d)), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
